// File: rtl/itcm_axi_rd_responder.sv
//------------------------------------------------------------------------------
// itcm_axi_rd_responder : AXI4 read responder serving IFU fetches from a
// 1-cycle-latency ITCM SRAM. Optional ITCM_RSP_STALL_EN adds a first-beat stall.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module itcm_axi_rd_responder #(
  parameter logic [31:0] BaseAddr = 32'h3000_0000,
  parameter int unsigned MemWords = 16384,
  parameter int unsigned IdWidth  = 4,
  parameter int unsigned StallCyc = 3
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        arvalid,
  output logic                        arready,
  input  logic [31:0]                 araddr,
  input  logic [IdWidth-1:0]          arid,
  input  logic [7:0]                  arlen,
  input  logic [2:0]                  arsize,
  input  logic [1:0]                  arburst,
  output logic                        rvalid,
  input  logic                        rready,
  output logic [31:0]                 rdata,
  output logic [1:0]                  rresp,
  output logic                        rlast,
  output logic [IdWidth-1:0]          rid,
  output logic                        mem_req,
  output logic [$clog2(MemWords)-1:0] mem_addr,
  input  logic [31:0]                 mem_rdata
);

  localparam int unsigned AddrW = $clog2(MemWords);
  localparam logic [32:0] SpanB = 33'(MemWords) << 2;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_STALL = 3'd1,
    S_REQ   = 3'd2,
    S_WAIT  = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  state_t             state_q;
  logic [31:0]        addr_q;
  logic [IdWidth-1:0] id_q;
  logic [7:0]         len_q;
  logic [1:0]         burst_q;
  logic               berr_q;
  logic [7:0]         cnt_q;
  logic               err_q;
  logic               arready_q;
  logic               rvalid_q;
  logic [31:0]        rdata_q;
  logic [1:0]         rresp_q;
  logic               rlast_q;
  logic [IdWidth-1:0] rid_q;
  logic               mem_req_q;
  logic [AddrW-1:0]   mem_addr_q;
`ifdef ITCM_RSP_STALL_EN
  logic [7:0]         stall_q;
`endif

  logic [31:0] wrap_mask;
  logic [31:0] addr_d;
  logic        ar_err;
  logic [31:0] req_addr;
  logic        req_berr;
  logic        req_err;

  function automatic logic out_of_range(input logic [31:0] a);
    logic [31:0] off;
    off = a - BaseAddr;
    return (a < BaseAddr) || ({1'b0, off} >= SpanB);
  endfunction

  function automatic logic [AddrW-1:0] word_idx(input logic [31:0] a);
    return AddrW'((a - BaseAddr) >> 2);
  endfunction

  // req_addr/req_err describe the beat about to enter REQ from whichever state leads there.
  always_comb begin
    wrap_mask = {22'd0, len_q, 2'b11};
    case (burst_q)
      2'b01:   addr_d = addr_q + 32'd4;
      2'b10:   addr_d = (addr_q & ~wrap_mask) | ((addr_q + 32'd4) & wrap_mask);
      default: addr_d = addr_q;
    endcase
    ar_err = (arsize != 3'b010) || (araddr[1:0] != 2'b00) ||
             ((arburst == 2'b10) && !(arlen inside {8'd1, 8'd3, 8'd7, 8'd15}));
    req_addr = addr_d;
    req_berr = berr_q;
    if (state_q == S_IDLE) begin
      req_addr = araddr;
      req_berr = ar_err;
    end else if (state_q == S_STALL) begin
      req_addr = addr_q;
    end
  end

  assign req_err = req_berr || out_of_range(req_addr);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      addr_q     <= 32'd0;
      id_q       <= '0;
      len_q      <= 8'd0;
      burst_q    <= 2'b00;
      berr_q     <= 1'b0;
      cnt_q      <= 8'd0;
      err_q      <= 1'b0;
      arready_q  <= 1'b1;
      rvalid_q   <= 1'b0;
      rdata_q    <= 32'd0;
      rresp_q    <= 2'b00;
      rlast_q    <= 1'b0;
      rid_q      <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
`ifdef ITCM_RSP_STALL_EN
      stall_q    <= 8'd0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (arvalid) begin
            addr_q    <= araddr;
            id_q      <= arid;
            len_q     <= arlen;
            burst_q   <= arburst;
            berr_q    <= ar_err;
            cnt_q     <= 8'd0;
            arready_q <= 1'b0;
`ifdef ITCM_RSP_STALL_EN
            if (StallCyc != 0) begin
              state_q <= S_STALL;
              stall_q <= 8'(StallCyc - 1);
            end else begin
              state_q    <= S_REQ;
              err_q      <= req_err;
              mem_req_q  <= !req_err;
              mem_addr_q <= word_idx(req_addr);
            end
`else
            state_q    <= S_REQ;
            err_q      <= req_err;
            mem_req_q  <= !req_err;
            mem_addr_q <= word_idx(req_addr);
`endif
          end
        end
`ifdef ITCM_RSP_STALL_EN
        S_STALL: begin
          if (stall_q == 8'd0) begin
            state_q    <= S_REQ;
            err_q      <= req_err;
            mem_req_q  <= !req_err;
            mem_addr_q <= word_idx(req_addr);
          end else begin
            stall_q <= stall_q - 8'd1;
          end
        end
`endif
        S_REQ: begin
          mem_req_q <= 1'b0;
          state_q   <= S_WAIT;
        end
        S_WAIT: begin
          rvalid_q <= 1'b1;
          rdata_q  <= err_q ? 32'd0 : mem_rdata;
          rresp_q  <= err_q ? 2'b10 : 2'b00;
          rlast_q  <= (cnt_q == len_q);
          rid_q    <= id_q;
          state_q  <= S_RESP;
        end
        S_RESP: begin
          if (rready) begin
            rvalid_q <= 1'b0;
            if (rlast_q) begin
              rlast_q   <= 1'b0;
              arready_q <= 1'b1;
              state_q   <= S_IDLE;
            end else begin
              addr_q     <= addr_d;
              cnt_q      <= cnt_q + 8'd1;
              state_q    <= S_REQ;
              err_q      <= req_err;
              mem_req_q  <= !req_err;
              mem_addr_q <= word_idx(req_addr);
            end
          end
        end
        default: begin
          state_q   <= S_IDLE;
          arready_q <= 1'b1;
          rvalid_q  <= 1'b0;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign arready  = arready_q;
  assign rvalid   = rvalid_q;
  assign rdata    = rdata_q;
  assign rresp    = rresp_q;
  assign rlast    = rlast_q;
  assign rid      = rid_q;
  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;

endmodule

`default_nettype wire

// File: tb/tb_itcm_axi_rd_responder.sv
//------------------------------------------------------------------------------
// tb_itcm_axi_rd_responder : directed plus randomized bursts against a
// behavioural beat model and an SRAM model with 1-cycle read latency.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_itcm_axi_rd_responder;

  localparam logic [31:0] BASE  = 32'h3000_0000;
  localparam int unsigned WORDS = 16384;
  localparam int unsigned IDW   = 4;

  logic            clock = 1'b0;
  logic            reset_n;
  logic            arvalid;
  logic            arready;
  logic [31:0]     araddr;
  logic [IDW-1:0]  arid;
  logic [7:0]      arlen;
  logic [2:0]      arsize;
  logic [1:0]      arburst;
  logic            rvalid;
  logic            rready;
  logic [31:0]     rdata;
  logic [1:0]      rresp;
  logic            rlast;
  logic [IDW-1:0]  rid;
  logic            mem_req;
  logic [13:0]     mem_addr;
  logic [31:0]     mem_rdata;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clock = ~clock;

  itcm_axi_rd_responder #(
    .BaseAddr (BASE),
    .MemWords (WORDS),
    .IdWidth  (IDW),
    .StallCyc (3)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .arvalid   (arvalid),
    .arready   (arready),
    .araddr    (araddr),
    .arid      (arid),
    .arlen     (arlen),
    .arsize    (arsize),
    .arburst   (arburst),
    .rvalid    (rvalid),
    .rready    (rready),
    .rdata     (rdata),
    .rresp     (rresp),
    .rlast     (rlast),
    .rid       (rid),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata)
  );

  function automatic logic [31:0] sram_word(input int unsigned idx);
    if (idx == 4) return 32'hDEAD_BEEF;
    return (idx * 32'h9E37_79B1) ^ 32'h0F0F_1234;
  endfunction

  always @(posedge clock) begin
    if (mem_req) mem_rdata <= sram_word(int'(mem_addr));
  end

  task automatic check_eq(input string tag, input longint unsigned act, input longint unsigned exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
  endtask

  // Beat address from the burst rules, expressed as offsets within the burst window.
  function automatic logic [31:0] exp_addr(input logic [31:0] a, input logic [1:0] b,
                                           input int len, input int i);
    longint unsigned bnd, base, aa;
    aa = {32'd0, a};
    case (b)
      2'b01: return 32'(aa + 4 * i);
      2'b10: begin
        bnd  = longint'(len + 1) * 4;
        base = aa - (aa % bnd);
        return 32'(base + ((aa - base) + 4 * i) % bnd);
      end
      default: return a;
    endcase
  endfunction

  function automatic bit exp_err(input logic [31:0] a0, input logic [2:0] size,
                                 input logic [1:0] b, input int len, input logic [31:0] ba);
    bit wrap_ok;
    longint unsigned x;
    wrap_ok = (len == 1) || (len == 3) || (len == 7) || (len == 15);
    x = {32'd0, ba};
    return (size != 3'd2) || (a0[1:0] != 2'b00) || ((b == 2'b10) && !wrap_ok) ||
           (x < {32'd0, BASE}) || (x >= {32'd0, BASE} + longint'(WORDS) * 4);
  endfunction

  // Called at a negedge with the DUT idle.
  task automatic do_burst(input logic [IDW-1:0] id, input logic [31:0] a, input int len,
                          input logic [2:0] size, input logic [1:0] b, input bit rnd,
                          input int hold_beat, input int hold_cyc, input int abort_beat);
    int cyc;
    int k;
    logic [31:0] ea, ed;
    bit ee;
    check_eq("arready_idle", arready, 1);
    arvalid = 1'b1; araddr = a; arid = id; arlen = 8'(len); arsize = size; arburst = b;
    @(posedge clock);
    @(negedge clock);
    arvalid = 1'b0; araddr = $urandom; arid = IDW'($urandom); arlen = 8'($urandom);
    arsize = 3'($urandom); arburst = 2'($urandom);
    cyc = 1;
    for (int i = 0; i <= len; i++) begin
      while (!rvalid && cyc < 10) begin
        check_eq("arready_busy", arready, 0);
        @(negedge clock);
        cyc++;
      end
      check_eq("latency", cyc, 3);
      if (!rvalid) return;
      if (i == abort_beat) begin
        reset_n = 1'b0;
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        check_eq("abort_rvalid", rvalid, 0);
        check_eq("abort_arready", arready, 1);
        check_eq("abort_mem_req", mem_req, 0);
        check_eq("abort_rlast", rlast, 0);
        check_eq("abort_rdata", rdata, 0);
        repeat (4) @(negedge clock);
        check_eq("abort_no_beat", rvalid, 0);
        return;
      end
      ea = exp_addr(a, b, len, i);
      ee = exp_err(a, size, b, len, ea);
      ed = ee ? 32'd0 : sram_word(int'((ea - BASE) >> 2) % WORDS);
      check_eq("rdata", rdata, ed);
      check_eq("rresp", rresp, ee ? 2 : 0);
      check_eq("rlast", rlast, (i == len) ? 1 : 0);
      check_eq("rid", rid, id);
      check_eq("arready_resp", arready, 0);
      if (i == hold_beat) begin
        rready = 1'b0;
        repeat (hold_cyc) begin
          @(negedge clock);
          check_eq("hold_rvalid", rvalid, 1);
          check_eq("hold_rdata", rdata, ed);
          check_eq("hold_rresp", rresp, ee ? 2 : 0);
          check_eq("hold_rlast", rlast, (i == len) ? 1 : 0);
          check_eq("hold_mem_req", mem_req, 0);
        end
      end
      k = 0;
      while (rnd && k < 6 && $urandom_range(0, 2) == 0) begin
        rready = 1'b0;
        @(negedge clock);
        check_eq("bp_rdata", rdata, ed);
        k++;
      end
      rready = 1'b1;
      @(posedge clock);
      @(negedge clock);
      rready = 1'b0;
      cyc = 1;
    end
    check_eq("arready_done", arready, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [2:0]  sz;
    logic [1:0]  b;
    int          len;
    int          sel;
    reset_n = 1'b0; arvalid = 1'b0; araddr = 32'd0; arid = '0; arlen = 8'd0;
    arsize = 3'd2; arburst = 2'b01; rready = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_eq("rst_arready", arready, 1);
    check_eq("rst_rvalid", rvalid, 0);
    check_eq("rst_rlast", rlast, 0);
    check_eq("rst_rresp", rresp, 0);
    check_eq("rst_rdata", rdata, 0);
    check_eq("rst_rid", rid, 0);
    check_eq("rst_mem_req", mem_req, 0);
    reset_n = 1'b1;
    @(negedge clock);

    do_burst(4'h1, 32'h3000_0010, 0, 3'd2, 2'b01, 1'b0, -1, 0, -1);
    do_burst(4'h5, BASE,          3, 3'd2, 2'b01, 1'b0, -1, 0, -1);
    do_burst(4'h2, BASE + 32'h8,  3, 3'd2, 2'b10, 1'b0, -1, 0, -1);
    do_burst(4'h3, BASE + 32'h40, 3, 3'd2, 2'b01, 1'b0,  1, 5, -1);
    do_burst(4'h4, BASE + WORDS * 4 - 4, 1, 3'd2, 2'b01, 1'b0, -1, 0, -1);
    do_burst(4'h6, BASE + 32'h20, 2, 3'd3, 2'b01, 1'b0, -1, 0, -1);
    do_burst(4'h9, BASE + 32'h60, 3, 3'd2, 2'b00, 1'b0, -1, 0, -1);
    do_burst(4'h7, BASE + 32'h100, 7, 3'd2, 2'b01, 1'b0, -1, 0, 1);
    do_burst(4'h8, BASE + 32'h30, 1, 3'd2, 2'b01, 1'b0, -1, 0, -1);

    for (int t = 0; t < 40; t++) begin
      sel = $urandom_range(0, 7);
      case (sel)
        0:       a = BASE - 32'(4 * $urandom_range(1, 4));
        1:       a = BASE + WORDS * 4 - 32'(4 * $urandom_range(0, 3));
        2:       a = BASE + 32'($urandom_range(0, 255));
        default: a = BASE + (32'($urandom_range(0, WORDS - 1)) << 2);
      endcase
      b  = 2'($urandom_range(0, 2));
      sz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'd2;
      if (b == 2'b10 && $urandom_range(0, 9) != 0) len = (2 << $urandom_range(0, 3)) - 1;
      else len = $urandom_range(0, 8);
      do_burst(IDW'($urandom), a, len, sz, b, 1'b1, -1, 0, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
